// File: rtl/sdram_req_responder_if.sv
// rtl/sdram_req_responder_if.sv - client request port and Avalon-MM master signals of the SDRAM responder
interface sdram_req_responder_if #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32
);
   logic              req_read;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_writedata;
   logic [DATA_W-1:0] req_readdata;
   logic              req_finished;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_write;
   logic [DATA_W-1:0] avm_writedata;
   logic              avm_waitrequest;
   logic [DATA_W-1:0] avm_readdata;
   logic              avm_readdatavalid;

   modport slave (
      input  req_read, req_write, req_addr, req_writedata,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid,
      output req_readdata, req_finished,
      output avm_address, avm_read, avm_write, avm_writedata
   );

   modport master (
      output req_read, req_write, req_addr, req_writedata,
      output avm_waitrequest, avm_readdata, avm_readdatavalid,
      input  req_readdata, req_finished,
      input  avm_address, avm_read, avm_write, avm_writedata
   );
endinterface

// File: rtl/sdram_req_responder.sv
// rtl/sdram_req_responder.sv - turns a level-held client request into one Avalon-MM transaction
// Optional read timeout (parameter TIMEOUT_CYC) is built when SDRAM_TIMEOUT_EN is defined.
module sdram_req_responder #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32
`ifdef SDRAM_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 64
`endif
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   sdram_req_responder_if.slave  bus,
   output logic                  o_busy,
   output logic                  o_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE_RD,
      S_WAIT_RD,
      S_ISSUE_WR,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              fin_q, fin_d;
   logic              err_q, err_d;
   logic              read_match;
   logic              write_match;

`ifdef SDRAM_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

   // finished is only granted if the client still holds the very request we served
   assign read_match  = bus.req_read  && (bus.req_addr == addr_q);
   assign write_match = bus.req_write && (bus.req_addr == addr_q);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      fin_d   = 1'b0;
      err_d   = err_q;
`ifdef SDRAM_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.req_read) begin
               addr_d  = bus.req_addr;
               rd_d    = 1'b1;
               state_d = S_ISSUE_RD;
               if (bus.req_write) err_d = 1'b1;
            end else if (bus.req_write) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_writedata;
               wr_d    = 1'b1;
               state_d = S_ISSUE_WR;
            end
         end
         S_ISSUE_RD: begin
`ifdef SDRAM_TIMEOUT_EN
            tmo_d = '0;
`endif
            if (bus.avm_waitrequest) rd_d = 1'b1;
            else                     state_d = S_WAIT_RD;
         end
         S_WAIT_RD: begin
            if (bus.avm_readdatavalid) begin
               rdata_d = bus.avm_readdata;
               fin_d   = read_match;
               state_d = S_DONE;
            end
`ifdef SDRAM_TIMEOUT_EN
            else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               fin_d   = read_match;
               state_d = S_DONE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
`endif
         end
         S_ISSUE_WR: begin
            if (bus.avm_waitrequest) begin
               wr_d = 1'b1;
            end else begin
               fin_d   = write_match;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef SDRAM_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         fin_q   <= fin_d;
         err_q   <= err_d;
`ifdef SDRAM_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign bus.avm_address   = addr_q;
   assign bus.avm_writedata = wdata_q;
   assign bus.avm_read      = rd_q;
   assign bus.avm_write     = wr_q;
   assign bus.req_readdata  = rdata_q;
   assign bus.req_finished  = fin_q;
   assign o_busy            = (state_q != S_IDLE);
   assign o_err             = err_q;

endmodule

// File: tb/tb_sdram_req_responder.sv
// tb/tb_sdram_req_responder.sv - scoreboard bench: client driver plus Avalon controller model
module tb_sdram_req_responder;
   localparam int ADDR_W = 23;
   localparam int DATA_W = 32;

   typedef struct {
      int               c;
      bit               wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } avm_t;
   typedef struct {
      int               c;
      logic [DATA_W-1:0] rd;
   } fin_t;

   logic i_clk = 1'b0;
   logic i_rst;
   logic o_busy, o_err;
   always #5 i_clk = ~i_clk;

   sdram_req_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sdram_req_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus.slave),
      .o_busy(o_busy),
      .o_err (o_err)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // controller knobs, written only by the main sequence
   int stall_cfg = 0;
   int lat_cfg = 2;
   bit no_return = 1'b0;

   // observations, written only by the controller/monitor
   avm_t got_avm[$];
   fin_t got_fin[$];
   int   wr_hi_cyc = 0;
   int   wd_changes = 0;

   // expectations, written only by the main sequence
   avm_t              exp_avm[$];
   logic [DATA_W-1:0] exp_fin[$];

   function automatic logic [DATA_W-1:0] data_for(input logic [ADDR_W-1:0] a);
      if (a == 23'h10) return 32'h1234_5678;
      return {9'h0, a} ^ 32'hA5A5_0000;
   endfunction

   // Avalon controller: data returns in the (L+1)th cycle after the accepting cycle
   int                stall_cnt = 0;
   int                pend = 0;
   logic [DATA_W-1:0] pend_data;
   bit                prev_wr = 1'b0;
   logic [DATA_W-1:0] prev_wd;
   always @(negedge i_clk) begin
      bus.avm_readdatavalid = 1'b0;
      bus.avm_waitrequest = 1'b0;
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata = pend_data;
         end
      end
      if (bus.avm_write === 1'b1) begin
         wr_hi_cyc = wr_hi_cyc + 1;
         if (prev_wr && bus.avm_writedata !== prev_wd) wd_changes = wd_changes + 1;
      end
      prev_wr = (bus.avm_write === 1'b1);
      prev_wd = bus.avm_writedata;
      if (bus.avm_read === 1'b1 || bus.avm_write === 1'b1) begin
         if (stall_cnt < stall_cfg) begin
            bus.avm_waitrequest = 1'b1;
            stall_cnt = stall_cnt + 1;
         end else begin
            stall_cnt = 0;
            got_avm.push_back('{cyc, bus.avm_write, bus.avm_address, bus.avm_writedata});
            if (bus.avm_read === 1'b1 && !no_return) begin
               pend = lat_cfg + 1;
               pend_data = data_for(bus.avm_address);
            end
         end
      end
      if (bus.req_finished === 1'b1) got_fin.push_back('{cyc, bus.req_readdata});
   end

   task automatic do_reset();
      i_rst = 1'b1;
      bus.req_read = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr = '0;
      bus.req_writedata = '0;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;
   endtask

   // drive one request, hold it until finished (bounded), drop it on the next edge
   task automatic client(input bit wr, input bit both, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input int max_cyc,
                         output int t0, output bit timed_out);
      @(posedge i_clk);
      #1;
      bus.req_read = !wr || both;
      bus.req_write = wr || both;
      bus.req_addr = a;
      bus.req_writedata = d;
      t0 = cyc;
      timed_out = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge i_clk);
         if (bus.req_finished === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
      end
      @(posedge i_clk);
      #1;
      bus.req_read = 1'b0;
      bus.req_write = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      tests_run++;
      if ({bus.avm_read, bus.avm_write, bus.req_finished, o_busy, o_err} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl got %b want 00000", {bus.avm_read, bus.avm_write, bus.req_finished, o_busy, o_err});
      end
      tests_run++;
      if ({bus.avm_address, bus.avm_writedata, bus.req_readdata} !== '0) begin
         tests_failed++;
         $display("FAIL reset_data got addr %h wd %h rd %h want 0", bus.avm_address, bus.avm_writedata, bus.req_readdata);
      end
   endtask

   task automatic test_read();
      int t0; bit to; int ai, fi; avm_t e; logic [DATA_W-1:0] ef;
      ai = got_avm.size(); fi = got_fin.size();
      lat_cfg = 2;
      exp_avm.push_back('{1, 1'b0, 23'h10, 32'h0});
      exp_fin.push_back(32'h1234_5678);
      client(1'b0, 1'b0, 23'h10, 32'h0, 40, t0, to);
      repeat (6) @(negedge i_clk);
      e = exp_avm.pop_front(); ef = exp_fin.pop_front();
      tests_run++;
      if (to || got_avm.size() - ai != 1 || got_fin.size() - fi != 1) begin
         tests_failed++;
         $display("FAIL read_count timeout %0d avm %0d fin %0d want 0 1 1", to, got_avm.size() - ai, got_fin.size() - fi);
      end else begin
         tests_run++;
         if (got_avm[ai].wr !== e.wr || got_avm[ai].addr !== e.addr || got_avm[ai].c - t0 != e.c) begin
            tests_failed++;
            $display("FAIL read_avm got wr %0d addr %h cyc %0d want wr 0 addr %h cyc %0d", got_avm[ai].wr, got_avm[ai].addr, got_avm[ai].c - t0, e.addr, e.c);
         end
         tests_run++;
         if (got_fin[fi].c - t0 != 5 || got_fin[fi].rd !== ef) begin
            tests_failed++;
            $display("FAIL read_fin got cyc %0d data %h want cyc 5 data %h", got_fin[fi].c - t0, got_fin[fi].rd, ef);
         end
      end
   endtask

   task automatic test_write();
      int t0; bit to; int ai, fi, wh, wc; avm_t e;
      ai = got_avm.size(); fi = got_fin.size(); wh = wr_hi_cyc; wc = wd_changes;
      stall_cfg = 3;
      exp_avm.push_back('{4, 1'b1, 23'hFF, 32'hCAFE_F00D});
      client(1'b1, 1'b0, 23'hFF, 32'hCAFE_F00D, 40, t0, to);
      repeat (4) @(negedge i_clk);
      stall_cfg = 0;
      e = exp_avm.pop_front();
      tests_run++;
      if (to || got_avm.size() - ai != 1 || got_fin.size() - fi != 1) begin
         tests_failed++;
         $display("FAIL write_count timeout %0d avm %0d fin %0d want 0 1 1", to, got_avm.size() - ai, got_fin.size() - fi);
      end else begin
         tests_run++;
         if (got_avm[ai].wr !== e.wr || got_avm[ai].addr !== e.addr || got_avm[ai].data !== e.data || got_avm[ai].c - t0 != e.c) begin
            tests_failed++;
            $display("FAIL write_avm got wr %0d addr %h data %h cyc %0d want wr 1 addr %h data %h cyc %0d", got_avm[ai].wr, got_avm[ai].addr, got_avm[ai].data, got_avm[ai].c - t0, e.addr, e.data, e.c);
         end
         tests_run++;
         if (got_fin[fi].c - got_avm[ai].c != 1) begin
            tests_failed++;
            $display("FAIL write_fin_latency got %0d want 1", got_fin[fi].c - got_avm[ai].c);
         end
      end
      tests_run++;
      if (wr_hi_cyc - wh != 4 || wd_changes != wc) begin
         tests_failed++;
         $display("FAIL write_strobe got high %0d changes %0d want 4 0", wr_hi_cyc - wh, wd_changes - wc);
      end
   endtask

   task automatic test_burst();
      int ai, fi; bit to; avm_t e; logic [DATA_W-1:0] ef;
      ai = got_avm.size(); fi = got_fin.size();
      to = 1'b0;
      @(posedge i_clk);
      #1 bus.req_read = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic [ADDR_W-1:0] a;
         bit seen;
         a = 23'h100 + ADDR_W'(i);
         bus.req_addr = a;
         exp_avm.push_back('{0, 1'b0, a, 32'h0});
         exp_fin.push_back(data_for(a));
         seen = 1'b0;
         for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge i_clk);
            seen = (bus.req_finished === 1'b1);
         end
         if (!seen) to = 1'b1;
         @(posedge i_clk);
         #1;
      end
      bus.req_read = 1'b0;
      repeat (10) @(negedge i_clk);
      tests_run++;
      if (to || got_avm.size() - ai != 4 || got_fin.size() - fi != 4) begin
         tests_failed++;
         $display("FAIL burst_count timeout %0d avm %0d fin %0d want 0 4 4", to, got_avm.size() - ai, got_fin.size() - fi);
      end
      for (int i = 0; i < 4; i++) begin
         e = exp_avm.pop_front(); ef = exp_fin.pop_front();
         if (got_avm.size() > ai + i && got_fin.size() > fi + i) begin
            tests_run++;
            if (got_avm[ai+i].wr !== 1'b0 || got_avm[ai+i].addr !== e.addr || got_fin[fi+i].rd !== ef) begin
               tests_failed++;
               $display("FAIL burst_%0d got wr %0d addr %h data %h want wr 0 addr %h data %h", i, got_avm[ai+i].wr, got_avm[ai+i].addr, got_fin[fi+i].rd, e.addr, ef);
            end
         end
      end
   endtask

   // client drops (chg=0) or moves (chg=1) its request while the read is in WAIT_RD
   task automatic test_abandon(input bit chg);
      int ai, fi, nfin; avm_t e;
      ai = got_avm.size(); fi = got_fin.size();
      lat_cfg = 6;
      exp_avm.push_back('{0, 1'b0, 23'h41, 32'h0});
      if (chg) begin
         exp_avm.push_back('{0, 1'b0, 23'h42, 32'h0});
         exp_fin.push_back(data_for(23'h42));
      end
      @(posedge i_clk);
      #1 bus.req_read = 1'b1; bus.req_addr = 23'h41;
      repeat (3) @(posedge i_clk);
      #1;
      if (chg) bus.req_addr = 23'h42;
      else     bus.req_read = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge i_clk);
         if (bus.req_finished === 1'b1) begin
            @(posedge i_clk);
            #1 bus.req_read = 1'b0;
         end
      end
      bus.req_read = 1'b0;
      nfin = chg ? 1 : 0;
      tests_run++;
      if (got_avm.size() - ai != 1 + nfin || got_fin.size() - fi != nfin || o_busy !== 1'b0 || o_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL abandon_%0d got avm %0d fin %0d busy %b err %b want %0d %0d 0 0", chg, got_avm.size() - ai, got_fin.size() - fi, o_busy, o_err, 1 + nfin, nfin);
      end
      for (int i = 0; i <= nfin; i++) begin
         e = exp_avm.pop_front();
         if (got_avm.size() > ai + i) begin
            tests_run++;
            if (got_avm[ai+i].addr !== e.addr || got_avm[ai+i].wr !== 1'b0) begin
               tests_failed++;
               $display("FAIL abandon_avm_%0d got addr %h want %h", i, got_avm[ai+i].addr, e.addr);
            end
         end
      end
      if (chg) begin
         logic [DATA_W-1:0] ef;
         ef = exp_fin.pop_front();
         if (got_fin.size() > fi) begin
            tests_run++;
            if (got_fin[fi].rd !== ef) begin
               tests_failed++;
               $display("FAIL abandon_data got %h want %h", got_fin[fi].rd, ef);
            end
         end
      end
      lat_cfg = 2;
   endtask

   task automatic test_reset_mid();
      int fi;
      fi = got_fin.size();
      lat_cfg = 4;
      @(posedge i_clk);
      #1 bus.req_read = 1'b1; bus.req_addr = 23'h50;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b1; bus.req_read = 1'b0;
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      tests_run++;
      if (bus.avm_read !== 1'b0 || o_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_idle got read %b busy %b want 0 0", bus.avm_read, o_busy);
      end
      repeat (12) @(negedge i_clk);
      tests_run++;
      if (got_fin.size() != fi || bus.req_readdata !== '0 || o_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_late got fin %0d data %h busy %b want 0 0 0", got_fin.size() - fi, bus.req_readdata, o_busy);
      end
      lat_cfg = 2;
   endtask

   task automatic test_conflict();
      int t0; bit to; int ai, fi, wh; avm_t e; logic [DATA_W-1:0] ef;
      ai = got_avm.size(); fi = got_fin.size(); wh = wr_hi_cyc;
      exp_avm.push_back('{0, 1'b0, 23'h20, 32'h0});
      exp_fin.push_back(data_for(23'h20));
      client(1'b0, 1'b1, 23'h20, 32'hDEAD_BEEF, 40, t0, to);
      e = exp_avm.pop_front(); ef = exp_fin.pop_front();
      tests_run++;
      if (o_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL conflict_err got %b want 1", o_err);
      end
      repeat (10) @(negedge i_clk);
      tests_run++;
      if (to || got_avm.size() - ai != 1 || got_fin.size() - fi != 1 || wr_hi_cyc != wh || o_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL conflict_count timeout %0d avm %0d fin %0d writes %0d err %b want 0 1 1 0 1", to, got_avm.size() - ai, got_fin.size() - fi, wr_hi_cyc - wh, o_err);
      end else begin
         tests_run++;
         if (got_avm[ai].wr !== 1'b0 || got_avm[ai].addr !== e.addr || got_fin[fi].rd !== ef) begin
            tests_failed++;
            $display("FAIL conflict_read got wr %0d addr %h data %h want 0 %h %h", got_avm[ai].wr, got_avm[ai].addr, got_fin[fi].rd, e.addr, ef);
         end
      end
      do_reset();
      @(negedge i_clk);
      tests_run++;
      if (o_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL conflict_clear got %b want 0", o_err);
      end
   endtask

`ifdef SDRAM_TIMEOUT_EN
   task automatic test_timeout();
      int t0; bit to; int fi;
      fi = got_fin.size();
      no_return = 1'b1;
      client(1'b0, 1'b0, 23'h60, 32'h0, 200, t0, to);
      no_return = 1'b0;
      tests_run++;
      if (to || got_fin.size() - fi != 1 || o_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_done timeout %0d fin %0d err %b want 0 1 1", to, got_fin.size() - fi, o_err);
      end else begin
         tests_run++;
         if (got_fin[fi].c - t0 != 66 || got_fin[fi].rd !== '0) begin
            tests_failed++;
            $display("FAIL timeout_fin got cyc %0d data %h want 66 0", got_fin[fi].c - t0, got_fin[fi].rd);
         end
      end
      do_reset();
   endtask
`endif

   initial begin
      do_reset();
      test_reset();
      test_read();
      test_write();
      test_burst();
      test_abandon(1'b0);
      test_abandon(1'b1);
      test_reset_mid();
      test_conflict();
`ifdef SDRAM_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
